dadda_cpa_pipe: RTL and testbench



---
 rtl/dadda_cpa_pipe.sv | 138 +++++++++++++
 tb/tb_dadda_cpa_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dadda_cpa_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dadda_cpa_pipe
// Description : Final carry-propagate adder of the 16x16 Dadda multiplier.
//               Adds the two reduced partial-product rows in a two-stage
//               split adder with a valid/ready handshake.
//               Stage 1 adds the low SPLIT bits and registers the carry.
//               Stage 2 adds the high bits plus that carry and holds the
//               product until the consumer takes it.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid/in_ready     - operand-pair handshake
//               row_a, row_b          - reduced sum/carry rows (WIDTH)
//               out_valid/out_ready   - result handshake
//               product               - (row_a + row_b) mod 2^WIDTH
//               ovf                   - carry out of bit WIDTH-1
// Revision    : 1.0 - initial release
// ============================================================================
module dadda_cpa_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_a,
    input  logic [WIDTH-1:0] row_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    localparam int c_HI_W = WIDTH - SPLIT;

    generate
        if ((WIDTH < 4) || (WIDTH % 2 != 0) || (SPLIT < 1) || (SPLIT >= WIDTH)) begin : g_param_check
            $error("dadda_cpa_pipe: illegal WIDTH/SPLIT combination");
        end
    endgenerate

    // Stage 1 state
    logic              r_s1_valid_q;
    logic [SPLIT-1:0]  r_lo_sum_q;
    logic              r_c_mid_q;
    logic [c_HI_W-1:0] r_a_hi_q;
    logic [c_HI_W-1:0] r_b_hi_q;

    // Stage 2 / output state
    logic              r_s2_valid_q;
    logic [WIDTH-1:0]  r_product_q;
    logic              r_ovf_q;

    // Next-state values
    logic              w_s1_valid_d;
    logic [SPLIT-1:0]  w_lo_sum_d;
    logic              w_c_mid_d;
    logic [c_HI_W-1:0] w_a_hi_d;
    logic [c_HI_W-1:0] w_b_hi_d;
    logic              w_s2_valid_d;
    logic [WIDTH-1:0]  w_product_d;
    logic              w_ovf_d;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic [SPLIT:0]    w_lo_full;
    logic [c_HI_W:0]   w_hi_full;

    // A stage may advance when it is empty or when the stage after it is
    // advancing; this lets s2 drain and refill on the same edge.
    assign w_s2_adv = !r_s2_valid_q || out_ready;
    assign w_s1_adv = !r_s1_valid_q || w_s2_adv;

    // One extra bit on each adder captures its carry out.
    assign w_lo_full = {1'b0, row_a[SPLIT-1:0]} + {1'b0, row_b[SPLIT-1:0]};
    assign w_hi_full = {1'b0, r_a_hi_q} + {1'b0, r_b_hi_q} + {{c_HI_W{1'b0}}, r_c_mid_q};

    always_comb begin
        w_s1_valid_d = r_s1_valid_q;
        w_lo_sum_d   = r_lo_sum_q;
        w_c_mid_d    = r_c_mid_q;
        w_a_hi_d     = r_a_hi_q;
        w_b_hi_d     = r_b_hi_q;
        if (w_s1_adv) begin
            w_s1_valid_d = in_valid;
            // Data only moves with a real operand pair so bubbles leave
            // the registers untouched.
            if (in_valid) begin
                w_lo_sum_d = w_lo_full[SPLIT-1:0];
                w_c_mid_d  = w_lo_full[SPLIT];
                w_a_hi_d   = row_a[WIDTH-1:SPLIT];
                w_b_hi_d   = row_b[WIDTH-1:SPLIT];
            end
        end
    end

    always_comb begin
        w_s2_valid_d = r_s2_valid_q;
        w_product_d  = r_product_q;
        w_ovf_d      = r_ovf_q;
        if (w_s2_adv) begin
            w_s2_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_product_d = {w_hi_full[c_HI_W-1:0], r_lo_sum_q};
                w_ovf_d     = w_hi_full[c_HI_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid_q <= 1'b0;
            r_lo_sum_q   <= '0;
            r_c_mid_q    <= 1'b0;
            r_a_hi_q     <= '0;
            r_b_hi_q     <= '0;
            r_s2_valid_q <= 1'b0;
            r_product_q  <= '0;
            r_ovf_q      <= 1'b0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_lo_sum_q   <= w_lo_sum_d;
            r_c_mid_q    <= w_c_mid_d;
            r_a_hi_q     <= w_a_hi_d;
            r_b_hi_q     <= w_b_hi_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_product_q  <= w_product_d;
            r_ovf_q      <= w_ovf_d;
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid_q;
    assign product   = r_product_q;
    assign ovf       = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dadda_cpa_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dadda_cpa_pipe
// Description : Self-checking bench for dadda_cpa_pipe. Directed vector
//               table, random multiply stream and hand-written handshake /
//               reset sequences. Inputs change on the falling clock edge,
//               outputs are sampled there as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dadda_cpa_pipe;

    localparam int c_WIDTH = 32;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [c_WIDTH-1:0]  row_a;
    logic [c_WIDTH-1:0]  row_b;
    logic                out_valid;
    logic                out_ready;
    logic [c_WIDTH-1:0]  product;
    logic                ovf;

    int n_pass;
    int n_total;

    dadda_cpa_pipe #(.WIDTH(c_WIDTH), .SPLIT(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_a     (row_a),
        .row_b     (row_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic        o;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    vec_t        vecs [8];
    logic [31:0] s_a   [64];
    logic [31:0] s_b   [64];
    logic [31:0] s_exp [64];

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        row_a     = '0;
        row_b     = '0;

        // Hand-computed sums: {row_a, row_b, product, ovf}
        vecs[0] = '{32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[2] = '{32'h80008000, 32'h80008000, 32'h00010000, 1'b1};
        vecs[3] = '{32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
        vecs[4] = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0};
        vecs[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
        vecs[7] = '{32'h7FFF8000, 32'h00008000, 32'h80000000, 1'b0};

        // ---------------- reset with random inputs ----------------
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            row_a     = $urandom;
            row_b     = $urandom;
        end
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product",   64'(product),   64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready",  64'(in_ready),  64'd1);

        // ---------------- directed single-beat vectors ----------------
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            row_a     = vecs[v].a;
            row_b     = vecs[v].b;
            #1 chk($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1_valid", v), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", v),   64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_product", v), 64'(product),   64'(vecs[v].p));
            chk($sformatf("vec%0d_ovf", v),     64'(ovf),       64'(vecs[v].o));
            @(negedge clk);
            chk($sformatf("vec%0d_one_cycle", v), 64'(out_valid), 64'd0);
        end

        // ---------------- streaming random multiplies ----------------
        for (int i = 0; i < 64; i++) begin
            logic [15:0] ma;
            logic [15:0] mb;
            logic [31:0] p;
            ma = 16'($urandom);
            mb = 16'($urandom);
            p  = 32'(ma) * 32'(mb);
            // Split the product into two rows whose sum never wraps.
            s_a[i]   = 32'(longint'($urandom) % (longint'(p) + 64'sd1));
            s_b[i]   = p - s_a[i];
            s_exp[i] = p;
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 68; cyc++) begin
            @(negedge clk);
            chk($sformatf("stream%0d_valid", cyc), 64'(out_valid), 64'((cyc >= 2) && (cyc < 66)));
            if (out_valid && (cyc >= 2) && (cyc < 66)) begin
                chk($sformatf("stream%0d_product", cyc - 2), 64'(product), 64'(s_exp[cyc-2]));
                chk($sformatf("stream%0d_ovf", cyc - 2),     64'(ovf),     64'd0);
            end
            if (cyc < 64) begin
                in_valid = 1'b1;
                row_a    = s_a[cyc];
                row_b    = s_b[cyc];
                #1 chk($sformatf("stream%0d_in_ready", cyc), 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
        end

        // ---------------- backpressure ----------------
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        row_a     = 32'h1;
        row_b     = 32'h2;
        #1 chk("bp_ready0", 64'(in_ready), 64'd1);
        @(negedge clk);
        row_a = 32'h3;
        row_b = 32'h4;
        #1 chk("bp_ready1", 64'(in_ready), 64'd1);
        @(negedge clk);
        row_a = 32'h5;
        row_b = 32'h6;
        #1 chk("bp_ready_full", 64'(in_ready), 64'd0);
        chk("bp_valid_full", 64'(out_valid), 64'd1);
        chk("bp_hold0",      64'(product),   64'h3);
        @(negedge clk);
        chk("bp_hold1",          64'(product),  64'h3);
        chk("bp_ready_still_0",  64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1 chk("bp_ready_drain", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_out1_valid", 64'(out_valid), 64'd1);
        chk("bp_out1",       64'(product),   64'h7);
        @(negedge clk);
        chk("bp_out2_valid", 64'(out_valid), 64'd1);
        chk("bp_out2",       64'(product),   64'hB);
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // ---------------- mid-operation reset ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        row_a     = 32'h1111;
        row_b     = 32'h2222;
        @(negedge clk);
        row_a = 32'h3333;
        row_b = 32'h4444;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_full_valid", 64'(out_valid), 64'd1);
        chk("mr_full_ready", 64'(in_ready),  64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_async_valid",   64'(out_valid), 64'd0);
        chk("mr_async_product", 64'(product),   64'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mr_stay_empty%0d", i), 64'(out_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
